// File: rtl/booth_pp_generator.sv
// Sequential radix-4 Booth partial-product generator feeding the 5-input PP adder tree.
// Define BOOTH_SIGNED_EN for two's-complement operands (4 digits, pp4 held at 0).
module booth_pp_generator #(
   parameter int OP_W  = 8,
   parameter int PP0_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    a_in,
   input  logic [OP_W-1:0]    b_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PP0_W-1:0]   pp0,
   output logic [PP0_W-3:0]   pp1,
   output logic [PP0_W-5:0]   pp2,
   output logic [PP0_W-7:0]   pp3,
   output logic [PP0_W-9:0]   pp4,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENC,
      S_DONE
   } state_t;

`ifdef BOOTH_SIGNED_EN
   localparam logic [2:0] LAST_IDX = 3'd3;
`else
   localparam logic [2:0] LAST_IDX = 3'd4;
`endif

   state_t            r_state;
   state_t            w_next;
   logic [2:0]        r_idx;
   logic [OP_W-1:0]   r_a;
   logic [OP_W-1:0]   r_b;
   logic [PP0_W-1:0]  r_pp0;
   logic [PP0_W-3:0]  r_pp1;
   logic [PP0_W-5:0]  r_pp2;
   logic [PP0_W-7:0]  r_pp3;
   logic [PP0_W-9:0]  r_pp4;

   logic [10:0]       w_bx;
   logic [2:0]        w_trip;
   logic [15:0]       w_a16;
   logic [15:0]       w_pp;
   logic              w_last;

`ifdef BOOTH_SIGNED_EN
   assign w_bx  = {r_b[7], r_b[7], r_b, 1'b0};
   assign w_a16 = {{8{r_a[7]}}, r_a};
`else
   assign w_bx  = {2'b00, r_b, 1'b0};
   assign w_a16 = {8'h00, r_a};
`endif

   assign w_last = (r_idx == LAST_IDX);

   always_comb begin
      w_trip = 3'b000;
      case (r_idx)
         3'd0:    w_trip = w_bx[2:0];
         3'd1:    w_trip = w_bx[4:2];
         3'd2:    w_trip = w_bx[6:4];
         3'd3:    w_trip = w_bx[8:6];
         3'd4:    w_trip = w_bx[10:8];
         default: w_trip = 3'b000;
      endcase
   end

   // Digit value times A, formed in 16-bit two's complement
   always_comb begin
      w_pp = 16'h0000;
      case (w_trip)
         3'b001, 3'b010: w_pp = w_a16;
         3'b011:         w_pp = w_a16 << 1;
         3'b100:         w_pp = -(w_a16 << 1);
         3'b101, 3'b110: w_pp = -w_a16;
         default:        w_pp = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_next = S_ENC;
         end
         S_ENC: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= 3'd0;
         r_a   <= '0;
         r_b   <= '0;
         r_pp0 <= '0;
         r_pp1 <= '0;
         r_pp2 <= '0;
         r_pp3 <= '0;
         r_pp4 <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a   <= a_in;
                  r_b   <= b_in;
                  r_idx <= 3'd0;
                  r_pp0 <= '0;
                  r_pp1 <= '0;
                  r_pp2 <= '0;
                  r_pp3 <= '0;
                  r_pp4 <= '0;
               end
            end
            S_ENC: begin
               r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
               case (r_idx)
                  3'd0: r_pp0 <= w_pp;
                  3'd1: r_pp1 <= w_pp[13:0];
                  3'd2: r_pp2 <= w_pp[11:0];
                  3'd3: r_pp3 <= w_pp[9:0];
`ifndef BOOTH_SIGNED_EN
                  3'd4: r_pp4 <= w_pp[7:0];
`endif
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign pp0 = r_pp0;
   assign pp1 = r_pp1;
   assign pp2 = r_pp2;
   assign pp3 = r_pp3;
   assign pp4 = r_pp4;

endmodule

// File: tb/tb_booth_pp_generator.sv
// Self-checking bench for booth_pp_generator: arithmetic Booth model plus directed vectors.
// Honors BOOTH_SIGNED_EN the same way the design does.
module tb_booth_pp_generator;

`ifdef BOOTH_SIGNED_EN
   localparam int ND  = 4;
   localparam bit SGN = 1'b1;
`else
   localparam int ND  = 5;
   localparam bit SGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  a_in = 8'h00;
   logic [7:0]  b_in = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [15:0] pp0;
   logic [13:0] pp1;
   logic [11:0] pp2;
   logic [9:0]  pp3;
   logic [7:0]  pp4;

   booth_pp_generator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pp0       (pp0),
      .pp1       (pp1),
      .pp2       (pp2),
      .pp3       (pp3),
      .pp4       (pp4),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Booth digit from the recoded multiplier, times A, kept to 16-2i bits
   function automatic logic [15:0] pp_model(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input int i);
      int bx, av, d, p, b2, b1, b0;
      logic [15:0] r;
      logic [15:0] mask;
      if (SGN && i == 4) return 16'h0000;
      if (SGN) begin
         bx = $signed(b);
         av = $signed(a);
      end else begin
         bx = int'(b);
         av = int'(a);
      end
      bx = bx * 2;
      b2 = int'(bx[2*i+2]);
      b1 = int'(bx[2*i+1]);
      b0 = int'(bx[2*i]);
      d = -2 * b2 + b1 + b0;
      p = d * av;
      r = p[15:0];
      mask = 16'hFFFF >> (2 * i);
      return r & mask;
   endfunction

   function automatic logic [15:0] prod_model(input logic [7:0] a,
                                              input logic [7:0] b);
      int x, y, p;
      if (SGN) begin
         x = $signed(a);
         y = $signed(b);
      end else begin
         x = int'(a);
         y = int'(b);
      end
      p = x * y;
      return p[15:0];
   endfunction

   function automatic logic [15:0] dut_sum();
      return pp0 + {pp1, 2'b00} + {pp2, 4'b0000} + {pp3, 6'b000000}
             + {pp4, 8'h00};
   endfunction

   // Cycle model: 0 idle, 1..ND encoding, ND+1 done
   int         m_cnt = 0;
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   bit         m_clean = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0;
         m_clean = 1'b1;
      end else if (m_cnt == 0) begin
         if (in_valid) begin
            m_a = a_in;
            m_b = b_in;
            m_cnt = 1;
            m_clean = 1'b0;
         end
      end else if (m_cnt <= ND) begin
         m_cnt++;
      end else if (out_ready) begin
         m_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 16'(in_ready), 16'(m_cnt == 0));
         chk("out_valid", 16'(out_valid), 16'(m_cnt == ND + 1));
         chk("busy", 16'(busy), 16'(m_cnt != 0));
         if (m_cnt == ND + 1) begin
            chk("pp0", pp0, pp_model(m_a, m_b, 0));
            chk("pp1", {2'b00, pp1}, pp_model(m_a, m_b, 1));
            chk("pp2", {4'h0, pp2}, pp_model(m_a, m_b, 2));
            chk("pp3", {6'h00, pp3}, pp_model(m_a, m_b, 3));
            chk("pp4", {8'h00, pp4}, pp_model(m_a, m_b, 4));
            chk("tree_sum", dut_sum(), prod_model(m_a, m_b));
         end
         if (m_clean) begin
            chk("pp_zero", pp0 | {2'b00, pp1} | {4'h0, pp2} | {6'h00, pp3}
                | {8'h00, pp4}, 16'h0000);
         end
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat);
      int n;
      n = 0;
      lat = 0;
      @(negedge clk);
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready stuck 0, required 1");
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int prev;
      int acc;
      int n;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 16'(in_ready), 16'h0001);
      chk("rst_out_valid", 16'(out_valid), 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0000);
      chk("rst_pp0", pp0, 16'h0000);
      chk("rst_pp4", {8'h00, pp4}, 16'h0000);
      rst = 1'b0;
      chk_en = 1'b1;

`ifndef BOOTH_SIGNED_EN
      chk("mdl_ffff_pp0", pp_model(8'hFF, 8'hFF, 0), 16'hFF01);
      chk("mdl_ffff_pp4", pp_model(8'hFF, 8'hFF, 4), 16'h00FF);
      chk("mdl_0302_pp0", pp_model(8'h03, 8'h02, 0), 16'hFFFA);
      chk("mdl_0302_pp1", pp_model(8'h03, 8'h02, 1), 16'h0003);

      run_op(8'hFF, 8'hFF, lat);
      chk("lat_ffff", 16'(lat), 16'd5);
      chk("ffff_pp0", pp0, 16'hFF01);
      chk("ffff_pp1", {2'b00, pp1}, 16'h0000);
      chk("ffff_pp2", {4'h0, pp2}, 16'h0000);
      chk("ffff_pp3", {6'h00, pp3}, 16'h0000);
      chk("ffff_pp4", {8'h00, pp4}, 16'h00FF);
      chk("ffff_sum", dut_sum(), 16'hFE01);

      run_op(8'h03, 8'h02, lat);
      chk("lat_0302", 16'(lat), 16'd5);
      chk("0302_pp0", pp0, 16'hFFFA);
      chk("0302_pp1", {2'b00, pp1}, 16'h0003);
      chk("0302_pp4", {8'h00, pp4}, 16'h0000);
      chk("0302_sum", dut_sum(), 16'h0006);
`else
      chk("mdl_fd02_pp0", pp_model(8'hFD, 8'h02, 0), 16'h0006);
      chk("mdl_fd02_pp1", pp_model(8'hFD, 8'h02, 1), 16'h3FFD);

      run_op(8'hFD, 8'h02, lat);
      chk("lat_fd02", 16'(lat), 16'd4);
      chk("fd02_pp0", pp0, 16'h0006);
      chk("fd02_pp1", {2'b00, pp1}, 16'h3FFD);
      chk("fd02_pp4", {8'h00, pp4}, 16'h0000);
      chk("fd02_sum", dut_sum(), 16'hFFFA);
`endif

      // Backpressure in DONE with a competing offer on the input
      @(negedge clk);
      out_ready = 1'b0;
      run_op(8'h5A, 8'hC3, lat);
      chk("lat_bp", 16'(lat), 16'(ND));
      in_valid = 1'b1;
      a_in = 8'h11;
      b_in = 8'h22;
      repeat (10) begin
         @(negedge clk);
         chk("bp_out_valid", 16'(out_valid), 16'h0001);
         chk("bp_in_ready", 16'(in_ready), 16'h0000);
         chk("bp_pp0", pp0, pp_model(8'h5A, 8'hC3, 0));
         chk("bp_sum", dut_sum(), prod_model(8'h5A, 8'hC3));
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_release_idle", 16'(in_ready), 16'h0001);
      chk("bp_release_ov", 16'(out_valid), 16'h0000);

      // Reset while encoding digit 2
      a_in = 8'h77;
      b_in = 8'h99;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", 16'(in_ready), 16'h0001);
      chk("abort_out_valid", 16'(out_valid), 16'h0000);
      chk("abort_busy", 16'(busy), 16'h0000);
      chk("abort_pp", pp0 | {2'b00, pp1} | {4'h0, pp2} | {6'h00, pp3}
          | {8'h00, pp4}, 16'h0000);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_ov", 16'(out_valid), 16'h0000);
      end

      // Streaming with out_ready tied high
      prev = -1;
      acc = 0;
      n = 0;
      while (acc < 256 && n < 4000) begin
         @(negedge clk);
         n++;
         if (in_ready) begin
            if (prev >= 0) chk("accept_spacing", 16'(cyc - prev), 16'(ND + 2));
            prev = cyc;
            acc++;
         end
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("stream_count", 16'(acc), 16'd256);
      repeat (ND + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
